ws2812_write_arbiter: RTL and testbench

Round-robin write arbiter in front of the `ws2812` driver's LED write port (`rgb_data`, `led_num`, `write`). It lets several requesters share that single port, such as a host register interface, a pattern generator and a fade engine. It accepts one write beat per cycle and supports locked bursts, so a requester can update a whole frame without interleaving. It also flags out-of-range LED indices and stalled bursts through sticky error bits.

---
 rtl/ws2812_write_arbiter_if.sv | 33 +++
 rtl/ws2812_write_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ws2812_write_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_write_arbiter_if
//  Description : Requester-side write-beat bus of the ws2812 write arbiter.
//                One lane per requester, packed side by side:
//                  req_valid   [NUM_REQ]     beat valid
//                  req_ready   [NUM_REQ]     beat accepted this cycle
//                  req_led_num [8*NUM_REQ]   LED index, lane i = [8i+7:8i]
//                  req_rgb     [24*NUM_REQ]  colour, lane i = [24i+23:24i]
//                  req_last    [NUM_REQ]     beat closes the burst
//                master : requester side; slave : arbiter side.
//  Revision    : 1.0  initial release
// ============================================================================
interface ws2812_write_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [8*NUM_REQ-1:0]  req_led_num;
  logic [24*NUM_REQ-1:0] req_rgb;
  logic [NUM_REQ-1:0]    req_last;

  modport master (
    output req_valid, req_led_num, req_rgb, req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_led_num, req_rgb, req_last,
    output req_ready
  );
endinterface
`default_nettype wire

// File: rtl/ws2812_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_write_arbiter
//  Description : Round-robin arbiter sharing the ws2812 LED write port among
//                up to four requesters, with locked bursts, LED index range
//                checking and a lock-idle timeout.
//  Ports       : clk, reset      clock / synchronous active-high reset
//                bus (slave)     requester beats (valid/ready/led/rgb/last)
//                clear_err       clears the sticky error flags
//                write, led_num, rgb_data   registered driver write port
//                grant_id        requester behind the current write beat
//                locked          a burst lock is held
//                err_range       sticky: out-of-range beat dropped
//                err_timeout     sticky: lock released by timeout
//  Revision    : 1.0  initial release
// ============================================================================
module ws2812_write_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int NUM_LEDS     = 8,
  parameter int LOCK_TIMEOUT = 255
) (
  input  wire logic              clk,
  input  wire logic              reset,
  ws2812_write_arbiter_if.slave  bus,
  input  wire logic              clear_err,
  output logic                   write,
  output logic [7:0]             led_num,
  output logic [23:0]            rgb_data,
  output logic [1:0]             grant_id,
  output logic                   locked,
  output logic                   err_range,
  output logic                   err_timeout
);

  localparam logic [8:0]  c_num_leds = 9'(NUM_LEDS);
  localparam logic [15:0] c_timeout  = 16'(LOCK_TIMEOUT);
  localparam logic [1:0]  c_last_req = 2'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t       state;
  logic [1:0]   lock_id;
  logic [1:0]   last_grant;
  logic [15:0]  tcount;

  logic [NUM_REQ-1:0] ready;
  logic [1:0]         gnt;
  logic               accept;
  logic               timeout_hit;
  logic [7:0]         sel_led;
  logic [23:0]        sel_rgb;
  logic               sel_last;
  logic               in_range;

  // The timeout cycle itself accepts nothing, even if the owner revalidates.
  assign timeout_hit = (state == LOCK) && (tcount == c_timeout);

  // Grant selection: depends only on valid bits and arbiter state, never on
  // beat payload, so ready has no path from led/rgb/last.
  always_comb begin
    ready  = '0;
    gnt    = lock_id;
    accept = 1'b0;
    if (state == ARB) begin
      // Walk priorities last_grant+1, +2, ... wrapping at NUM_REQ.
      for (int k = 1; k <= NUM_REQ; k++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!accept && (i == (int'(last_grant) + k) % NUM_REQ) && bus.req_valid[i]) begin
            ready[i] = 1'b1;
            gnt      = 2'(i);
            accept   = 1'b1;
          end
        end
      end
    end else if (!timeout_hit) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if ((2'(i) == lock_id) && bus.req_valid[i]) begin
          ready[i] = 1'b1;
          accept   = 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = ready;

  // Payload of the granted lane.
  always_comb begin
    sel_led  = '0;
    sel_rgb  = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (2'(i) == gnt) begin
        sel_led  = bus.req_led_num[8*i +: 8];
        sel_rgb  = bus.req_rgb[24*i +: 24];
        sel_last = bus.req_last[i];
      end
    end
  end

  assign in_range = ({1'b0, sel_led} < c_num_leds);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARB;
      lock_id     <= '0;
      last_grant  <= c_last_req;
      tcount      <= '0;
      write       <= 1'b0;
      led_num     <= '0;
      rgb_data    <= '0;
      grant_id    <= '0;
      locked      <= 1'b0;
      err_range   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      write <= 1'b0;

      // A new error event beats a simultaneous clear.
      err_range   <= (accept && !in_range) || (err_range && !clear_err);
      err_timeout <= timeout_hit || (err_timeout && !clear_err);

      if (accept) begin
        last_grant <= gnt;
        if (in_range) begin
          write    <= 1'b1;
          led_num  <= sel_led;
          rgb_data <= sel_rgb;
          grant_id <= gnt;
        end
      end

      case (state)
        ARB: begin
          if (accept && !sel_last) begin
            state   <= LOCK;
            lock_id <= gnt;
            tcount  <= '0;
            locked  <= 1'b1;
          end
        end
        LOCK: begin
          if (timeout_hit) begin
            state  <= ARB;
            locked <= 1'b0;
          end else if (accept) begin
            tcount <= '0;
            if (sel_last) begin
              state  <= ARB;
              locked <= 1'b0;
            end
          end else begin
            // Not accepting outside the timeout cycle means the owner is idle.
            tcount <= tcount + 16'd1;
          end
        end
        default: begin
          state  <= ARB;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ws2812_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ws2812_write_arbiter
//  Description : Directed self-checking bench for ws2812_write_arbiter with
//                NUM_REQ=2, NUM_LEDS=8, LOCK_TIMEOUT=4.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ws2812_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_err;
  logic        write;
  logic [7:0]  led_num;
  logic [23:0] rgb_data;
  logic [1:0]  grant_id;
  logic        locked;
  logic        err_range;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  ws2812_write_arbiter_if #(.NUM_REQ(2)) bus ();

  ws2812_write_arbiter #(
    .NUM_REQ      (2),
    .NUM_LEDS     (8),
    .LOCK_TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .clear_err   (clear_err),
    .write       (write),
    .led_num     (led_num),
    .rgb_data    (rgb_data),
    .grant_id    (grant_id),
    .locked      (locked),
    .err_range   (err_range),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input logic v, input logic [7:0] led,
                       input logic [23:0] rgb, input logic last);
    bus.req_valid[r]          = v;
    bus.req_led_num[8*r +: 8] = led;
    bus.req_rgb[24*r +: 24]   = rgb;
    bus.req_last[r]           = last;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset           = 1'b0;
    clear_err       = 1'b0;
    bus.req_valid   = '0;
    bus.req_led_num = '0;
    bus.req_rgb     = '0;
    bus.req_last    = '0;
    #1;
    do_reset();

    // Reset state
    check("rst_write",  {31'd0, write}, 32'd0);
    check("rst_led",    {24'd0, led_num}, 32'd0);
    check("rst_rgb",    {8'd0, rgb_data}, 32'd0);
    check("rst_grant",  {30'd0, grant_id}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_errs",   {30'd0, err_range, err_timeout}, 32'd0);
    check("rst_ready",  {30'd0, bus.req_ready}, 32'd0);

    // Single write
    drive(0, 1'b1, 8'd3, 24'h123456, 1'b1);
    #1;
    check("single_ready", {30'd0, bus.req_ready}, 32'h1);
    tick();
    drive(0, 1'b0, 8'd0, 24'h0, 1'b0);
    check("single_write",  {31'd0, write}, 32'd1);
    check("single_led",    {24'd0, led_num}, 32'd3);
    check("single_rgb",    {8'd0, rgb_data}, 32'h123456);
    check("single_grant",  {30'd0, grant_id}, 32'd0);
    check("single_locked", {31'd0, locked}, 32'd0);
    tick();
    check("single_one_pulse", {31'd0, write}, 32'd0);
    check("single_led_hold",  {24'd0, led_num}, 32'd3);

    // Round robin from reset: grants 0,1,0,1
    do_reset();
    drive(0, 1'b1, 8'd1, 24'hAAAAAA, 1'b1);
    drive(1, 1'b1, 8'd2, 24'hBBBBBB, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_ready", {30'd0, bus.req_ready}, (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      check("rr_write", {31'd0, write}, 32'd1);
      check("rr_grant", {30'd0, grant_id}, 32'(i % 2));
      check("rr_led",   {24'd0, led_num}, (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    drive(0, 1'b0, 8'd0, 24'h0, 1'b0);
    drive(1, 1'b0, 8'd0, 24'h0, 1'b0);

    // Locked burst by req1 while req0 also requests
    for (int b = 0; b < 8; b++) begin
      drive(1, 1'b1, 8'(b), 24'h0A0000 | 24'(b), (b == 7));
      if (b > 0) drive(0, 1'b1, 8'd5, 24'h050505, 1'b1);
      #1;
      check("burst_ready", {30'd0, bus.req_ready}, 32'h2);
      tick();
      check("burst_write",  {31'd0, write}, 32'd1);
      check("burst_led",    {24'd0, led_num}, 32'(b));
      check("burst_rgb",    {8'd0, rgb_data}, 32'h0A0000 | 32'(b));
      check("burst_grant",  {30'd0, grant_id}, 32'd1);
      check("burst_locked", {31'd0, locked}, (b < 7) ? 32'd1 : 32'd0);
    end
    drive(1, 1'b0, 8'd0, 24'h0, 1'b0);
    #1;
    check("post_burst_ready", {30'd0, bus.req_ready}, 32'h1);
    tick();
    drive(0, 1'b0, 8'd0, 24'h0, 1'b0);
    check("post_burst_grant", {30'd0, grant_id}, 32'd0);
    check("post_burst_led",   {24'd0, led_num}, 32'd5);

    // Range error, then clear racing a second bad beat
    drive(0, 1'b1, 8'd8, 24'hFFFFFF, 1'b1);
    #1;
    check("range_ready", {30'd0, bus.req_ready}, 32'h1);
    tick();
    check("range_nowrite", {31'd0, write}, 32'd0);
    check("range_err",     {31'd0, err_range}, 32'd1);
    check("range_led_hold", {24'd0, led_num}, 32'd5);
    drive(0, 1'b1, 8'd9, 24'hFFFFFF, 1'b1);
    clear_err = 1'b1;
    tick();
    check("range_set_wins", {31'd0, err_range}, 32'd1);
    check("range_nowrite2", {31'd0, write}, 32'd0);
    drive(0, 1'b0, 8'd0, 24'h0, 1'b0);
    tick();
    clear_err = 1'b0;
    check("range_cleared", {31'd0, err_range}, 32'd0);

    // Timeout: one lock-opening beat, then owner goes idle
    drive(0, 1'b1, 8'd2, 24'h222222, 1'b0);
    #1;
    check("to_open_ready", {30'd0, bus.req_ready}, 32'h1);
    tick();
    drive(0, 1'b0, 8'd0, 24'h0, 1'b0);
    drive(1, 1'b1, 8'd6, 24'h666666, 1'b1);
    check("to_open_write",  {31'd0, write}, 32'd1);
    check("to_open_locked", {31'd0, locked}, 32'd1);
    for (int c = 1; c <= 5; c++) begin
      #1;
      check("to_blocked",    {30'd0, bus.req_ready}, 32'h0);
      check("to_locked",     {31'd0, locked}, 32'd1);
      check("to_err_early",  {31'd0, err_timeout}, 32'd0);
      tick();
    end
    check("to_released", {31'd0, locked}, 32'd0);
    check("to_err",      {31'd0, err_timeout}, 32'd1);
    check("to_req1_ready", {30'd0, bus.req_ready}, 32'h2);
    tick();
    drive(1, 1'b0, 8'd0, 24'h0, 1'b0);
    check("to_req1_write", {31'd0, write}, 32'd1);
    check("to_req1_grant", {30'd0, grant_id}, 32'd1);
    check("to_req1_led",   {24'd0, led_num}, 32'd6);

    // Reset in the middle of a req0 burst
    for (int b = 0; b < 3; b++) begin
      drive(0, 1'b1, 8'(b), 24'h303030, 1'b0);
      #1;
      check("mid_ready", {30'd0, bus.req_ready}, 32'h1);
      tick();
    end
    check("mid_locked", {31'd0, locked}, 32'd1);
    check("mid_err_sticky", {31'd0, err_timeout}, 32'd1);
    drive(0, 1'b1, 8'd3, 24'h303030, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_write",  {31'd0, write}, 32'd0);
    check("mid_rst_locked", {31'd0, locked}, 32'd0);
    check("mid_rst_errs",   {30'd0, err_range, err_timeout}, 32'd0);
    check("mid_rst_led",    {24'd0, led_num}, 32'd0);
    drive(0, 1'b1, 8'd4, 24'h444444, 1'b1);
    drive(1, 1'b1, 8'd7, 24'h777777, 1'b1);
    #1;
    check("mid_first_ready", {30'd0, bus.req_ready}, 32'h1);
    tick();
    drive(0, 1'b0, 8'd0, 24'h0, 1'b0);
    drive(1, 1'b0, 8'd0, 24'h0, 1'b0);
    check("mid_first_grant", {30'd0, grant_id}, 32'd0);
    check("mid_first_led",   {24'd0, led_num}, 32'd4);
    check("mid_first_write", {31'd0, write}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
